// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU function codes, register ids
// and the instruction-length decode used by fetch.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_t;

  // Unknown icodes are treated as one byte long so valP stays defined.
  function automatic logic [3:0] inst_len(input logic [3:0] ic);
    case (ic)
      I_HALT, I_NOP, I_RET:          inst_len = 4'd1;
      I_CMOV, I_OP, I_PUSH, I_POP:   inst_len = 4'd2;
      I_JXX, I_CALL:                 inst_len = 4'd9;
      I_IRMOV, I_RMMOV, I_MRMOV:     inst_len = 4'd10;
      default:                       inst_len = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu.sv
// 64-bit Y86 ALU: computes b OP a and the flags the condition codes latch.
module y86_alu
  import y86_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [1:0]  fun,
  output logic [63:0] result,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  // Arithmetic, logic and overflow detection; subtract is b - a.
  always_comb begin
    result = 64'd0;
    of     = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = b + a;
        of     = (a[63] == b[63]) && (result[63] != a[63]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (a[63] != b[63]) && (result[63] != b[63]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = 64'd0;
    endcase
    zf = (result == 64'd0);
    sf = result[63];
  end

endmodule

// File: rtl/y86_seq_core_fde.sv
// SEQ Y86-64 fetch, decode/write-back and execute. Memory access and next-PC
// selection live outside; valM comes in, valC/valP/cnd go out.
module y86_seq_core_fde
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pc,
  input  logic        imem_we,
  input  logic [9:0]  imem_waddr,
  input  logic [7:0]  imem_wdata,
  input  logic [63:0] valM,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] valE,
  output logic        cnd,
  output logic        ZF,
  output logic        SF,
  output logic        OF,
  output logic        invalid_inst,
  output logic        imem_error,
  output logic        halt,
  output logic [63:0] reg_bank0,
  output logic [63:0] reg_bank1,
  output logic [63:0] reg_bank2,
  output logic [63:0] reg_bank3,
  output logic [63:0] reg_bank4,
  output logic [63:0] reg_bank5,
  output logic [63:0] reg_bank6,
  output logic [63:0] reg_bank7,
  output logic [63:0] reg_bank8,
  output logic [63:0] reg_bank9,
  output logic [63:0] reg_bank10,
  output logic [63:0] reg_bank11,
  output logic [63:0] reg_bank12,
  output logic [63:0] reg_bank13,
  output logic [63:0] reg_bank14
);

  localparam int AW = $clog2(IMEM_BYTES);

  logic [7:0]  imem_r [IMEM_BYTES];
  logic [7:0]  ibyte_s [10];
  logic [63:0] waddr_s;
  logic [3:0]  len_s;
  logic        need_regids_s;

  logic [63:0] regs_r [15];
  logic        zf_r, sf_r, of_r;

  logic [63:0] alu_a_s, alu_b_s, alu_res_s;
  logic [1:0]  alu_fun_s;
  logic        alu_zf_s, alu_sf_s, alu_of_s;
  logic [3:0]  dst_e_s, dst_m_s;
  logic        commit_s;

  // ---------------- Fetch ----------------
  assign waddr_s = 64'(imem_waddr);

  // Instruction memory load port; contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we && (waddr_s < 64'(IMEM_BYTES))) begin
      imem_r[waddr_s[AW-1:0]] <= imem_wdata;
    end
  end

  for (genvar gi = 0; gi < 10; gi++) begin : g_fetch
    logic [63:0] faddr_s;
    assign faddr_s     = pc + 64'(gi);
    assign ibyte_s[gi] = (faddr_s < 64'(IMEM_BYTES)) ? imem_r[faddr_s[AW-1:0]] : 8'h00;
  end

  assign icode = ibyte_s[0][7:4];
  assign ifun  = ibyte_s[0][3:0];
  assign len_s = inst_len(icode);
  assign valP  = pc + 64'(len_s);

  assign need_regids_s = (icode == I_CMOV)  || (icode == I_IRMOV) || (icode == I_RMMOV) ||
                         (icode == I_MRMOV) || (icode == I_OP)    || (icode == I_PUSH)  ||
                         (icode == I_POP);
  assign rA = need_regids_s ? ibyte_s[1][7:4] : RNONE;
  assign rB = need_regids_s ? ibyte_s[1][3:0] : RNONE;

  // Little-endian constant; its position depends on whether a register byte precedes it.
  always_comb begin
    case (icode)
      I_IRMOV, I_RMMOV, I_MRMOV:
        valC = {ibyte_s[9], ibyte_s[8], ibyte_s[7], ibyte_s[6],
                ibyte_s[5], ibyte_s[4], ibyte_s[3], ibyte_s[2]};
      I_JXX, I_CALL:
        valC = {ibyte_s[8], ibyte_s[7], ibyte_s[6], ibyte_s[5],
                ibyte_s[4], ibyte_s[3], ibyte_s[2], ibyte_s[1]};
      default: valC = 64'd0;
    endcase
  end

  // Legal ifun ranges per icode.
  always_comb begin
    case (icode)
      I_OP:          invalid_inst = (ifun > 4'd3);
      I_CMOV, I_JXX: invalid_inst = (ifun > 4'd6);
      I_HALT, I_NOP, I_IRMOV, I_RMMOV, I_MRMOV, I_CALL, I_RET, I_PUSH, I_POP:
                     invalid_inst = (ifun != 4'd0);
      default:       invalid_inst = 1'b1;
    endcase
  end

  assign imem_error = ((valP - 64'd1) >= 64'(IMEM_BYTES));
  assign halt       = (icode == I_HALT) && !imem_error;
  assign commit_s   = !(invalid_inst || imem_error || halt);

  // ---------------- Decode ----------------
  function automatic logic [63:0] rd_reg(input logic [3:0] id);
    if (id == RNONE) begin
      rd_reg = 64'd0;
    end else begin
      rd_reg = regs_r[id];
    end
  endfunction

  // Operand A source select.
  always_comb begin
    case (icode)
      I_CMOV, I_RMMOV, I_OP, I_PUSH: valA = rd_reg(rA);
      I_RET, I_POP:                  valA = rd_reg(RSP);
      default:                       valA = 64'd0;
    endcase
  end

  // Operand B source select.
  always_comb begin
    case (icode)
      I_RMMOV, I_MRMOV, I_OP:        valB = rd_reg(rB);
      I_CALL, I_RET, I_PUSH, I_POP:  valB = rd_reg(RSP);
      default:                       valB = 64'd0;
    endcase
  end

  // ---------------- Execute ----------------
  // Every valE form is routed through the single ALU as b OP a.
  always_comb begin
    alu_a_s   = 64'd0;
    alu_b_s   = 64'd0;
    alu_fun_s = ALU_ADD;
    case (icode)
      I_CMOV:           alu_a_s = valA;
      I_IRMOV:          alu_a_s = valC;
      I_RMMOV, I_MRMOV: begin
        alu_a_s = valC;
        alu_b_s = valB;
      end
      I_OP: begin
        alu_a_s   = valA;
        alu_b_s   = valB;
        alu_fun_s = ifun[1:0];
      end
      I_CALL, I_PUSH: begin
        alu_a_s   = 64'd8;
        alu_b_s   = valB;
        alu_fun_s = ALU_SUB;
      end
      I_RET, I_POP: begin
        alu_a_s = 64'd8;
        alu_b_s = valB;
      end
      default: alu_a_s = 64'd0;
    endcase
  end

  y86_alu u_alu (
    .a      (alu_a_s),
    .b      (alu_b_s),
    .fun    (alu_fun_s),
    .result (alu_res_s),
    .zf     (alu_zf_s),
    .sf     (alu_sf_s),
    .of     (alu_of_s)
  );

  assign valE = alu_res_s;

  // Branch / conditional-move predicate from the committed condition codes.
  always_comb begin
    case (ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (sf_r ^ of_r) | zf_r;
      4'd2:    cnd = sf_r ^ of_r;
      4'd3:    cnd = zf_r;
      4'd4:    cnd = !zf_r;
      4'd5:    cnd = !(sf_r ^ of_r);
      4'd6:    cnd = !(sf_r ^ of_r) && !zf_r;
      default: cnd = 1'b0;
    endcase
  end

  // ---------------- Write-back ----------------
  // Destination register selection for the ALU and memory results.
  always_comb begin
    case (icode)
      I_IRMOV, I_OP:                 dst_e_s = rB;
      I_CMOV:                        dst_e_s = cnd ? rB : RNONE;
      I_CALL, I_RET, I_PUSH, I_POP:  dst_e_s = RSP;
      default:                       dst_e_s = RNONE;
    endcase
    if ((icode == I_MRMOV) || (icode == I_POP)) begin
      dst_m_s = rA;
    end else begin
      dst_m_s = RNONE;
    end
  end

  // Register file and condition codes; the valM write is issued last so it
  // wins when both destinations coincide (popq %rsp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs_r[i] <= 64'd0;
      end
      zf_r <= 1'b1;
      sf_r <= 1'b0;
      of_r <= 1'b0;
    end else if (commit_s) begin
      if (dst_e_s != RNONE) begin
        regs_r[dst_e_s] <= valE;
      end
      if (dst_m_s != RNONE) begin
        regs_r[dst_m_s] <= valM;
      end
      if (icode == I_OP) begin
        zf_r <= alu_zf_s;
        sf_r <= alu_sf_s;
        of_r <= alu_of_s;
      end
    end
  end

  assign ZF = zf_r;
  assign SF = sf_r;
  assign OF = of_r;

  assign reg_bank0  = regs_r[0];
  assign reg_bank1  = regs_r[1];
  assign reg_bank2  = regs_r[2];
  assign reg_bank3  = regs_r[3];
  assign reg_bank4  = regs_r[4];
  assign reg_bank5  = regs_r[5];
  assign reg_bank6  = regs_r[6];
  assign reg_bank7  = regs_r[7];
  assign reg_bank8  = regs_r[8];
  assign reg_bank9  = regs_r[9];
  assign reg_bank10 = regs_r[10];
  assign reg_bank11 = regs_r[11];
  assign reg_bank12 = regs_r[12];
  assign reg_bank13 = regs_r[13];
  assign reg_bank14 = regs_r[14];

endmodule

// File: tb/tb_y86_seq_core_fde.sv
// Directed table-driven bench for y86_seq_core_fde: a small program is loaded,
// each instruction is checked combinationally and again after its commit edge.
module tb_y86_seq_core_fde;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc, valM;
  logic        imem_we;
  logic [9:0]  imem_waddr;
  logic [7:0]  imem_wdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, valA, valB, valE;
  logic        cnd, ZF, SF, OF, invalid_inst, imem_error, halt;
  logic [63:0] rb [15];

  int checks = 0;
  int errors = 0;

  logic [7:0] prog [1024];

  typedef struct {
    logic [63:0] pc, valm;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, vala, valb, vale;
    logic        cnd;
    logic [2:0]  st;   // {invalid_inst, imem_error, halt}
    int          r1;
    logic [63:0] v1;
    int          r2;
    logic [63:0] v2;
    logic [2:0]  cc;   // {ZF, SF, OF} after the edge
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  y86_seq_core_fde #(.IMEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .valM(valM), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .valA(valA), .valB(valB), .valE(valE),
    .cnd(cnd), .ZF(ZF), .SF(SF), .OF(OF),
    .invalid_inst(invalid_inst), .imem_error(imem_error), .halt(halt),
    .reg_bank0(rb[0]), .reg_bank1(rb[1]), .reg_bank2(rb[2]), .reg_bank3(rb[3]),
    .reg_bank4(rb[4]), .reg_bank5(rb[5]), .reg_bank6(rb[6]), .reg_bank7(rb[7]),
    .reg_bank8(rb[8]), .reg_bank9(rb[9]), .reg_bank10(rb[10]), .reg_bank11(rb[11]),
    .reg_bank12(rb[12]), .reg_bank13(rb[13]), .reg_bank14(rb[14])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic put(input int a, input logic [7:0] b);
    prog[a] = b;
  endtask

  task automatic put64(input int a, input logic [63:0] v);
    for (int k = 0; k < 8; k++) prog[a + k] = v[8*k +: 8];
  endtask

  task automatic add(input logic [63:0] p, input logic [63:0] vm,
                     input logic [3:0] ic, input logic [3:0] fn,
                     input logic [3:0] ra, input logic [3:0] rbi,
                     input logic [63:0] vc, input logic [63:0] vp,
                     input logic [63:0] va, input logic [63:0] vb,
                     input logic [63:0] ve, input logic c, input logic [2:0] st,
                     input int r1, input logic [63:0] v1,
                     input int r2, input logic [63:0] v2, input logic [2:0] cc);
    vec_t v;
    v.pc = p; v.valm = vm; v.icode = ic; v.ifun = fn; v.ra = ra; v.rb = rbi;
    v.valc = vc; v.valp = vp; v.vala = va; v.valb = vb; v.vale = ve;
    v.cnd = c; v.st = st; v.r1 = r1; v.v1 = v1; v.r2 = r2; v.v2 = v2; v.cc = cc;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; pc = 64'd2000; valM = 64'd0;
    imem_we = 1'b0; imem_waddr = 10'd0; imem_wdata = 8'd0;

    for (int i = 0; i < 1024; i++) prog[i] = 8'h00;
    put(0, 8'h30);   put(1, 8'hF0);   put64(2, 64'd10);          // irmovq $10,%rax
    put(10, 8'h30);  put(11, 8'hF3);  put64(12, 64'd3);          // irmovq $3,%rbx
    put(20, 8'h60);  put(21, 8'h03);                             // addq %rax,%rbx
    put(22, 8'h61);  put(23, 8'h33);                             // subq %rbx,%rbx
    put(24, 8'h74);  put64(25, 64'h1111);                        // jne
    put(33, 8'h73);  put64(34, 64'h40);                          // je
    put(42, 8'h30);  put(43, 8'hF0);  put64(44, 64'h7FFF_FFFF_FFFF_FFFF);
    put(52, 8'h30);  put(53, 8'hF3);  put64(54, 64'd1);
    put(62, 8'h60);  put(63, 8'h03);                             // addq overflow
    put(64, 8'h30);  put(65, 8'hF4);  put64(66, 64'h100);        // irmovq $0x100,%rsp
    put(74, 8'h30);  put(75, 8'hF0);  put64(76, 64'd5);          // irmovq $5,%rax
    put(84, 8'hA0);  put(85, 8'h0F);                             // pushq %rax
    put(86, 8'hB0);  put(87, 8'h1F);                             // popq %rcx
    put(88, 8'hC0);                                              // illegal icode
    put(89, 8'h00);                                              // halt
    put(90, 8'hB0);  put(91, 8'h4F);                             // popq %rsp
    put(92, 8'h20);  put(93, 8'h01);                             // rrmovq %rax,%rcx
    put(94, 8'h22);  put(95, 8'h03);                             // cmovl %rax,%rbx
    put(96, 8'h50);  put(97, 8'h24);  put64(98, 64'd8);          // mrmovq 8(%rsp),%rdx
    put(106, 8'h31); put(107, 8'hF0); put64(108, 64'h99);        // irmovq, bad ifun
    put(200, 8'h10);                                             // nop, overwritten later
    put(1020, 8'h30); put(1021, 8'hF0); put(1022, 8'hAB);        // straddles imem end

    //   pc   valM     ic    fn    rA    rB    valC         valP      valA         valB      valE                    cnd   st      r1 v1 r2 v2 cc
    add(0,    0,       4'h3, 4'h0, 4'hF, 4'h0, 10,          10,       0,           0,        10,                     1'b1, 3'b000, 0, 10, 3, 0, 3'b100);
    add(10,   0,       4'h3, 4'h0, 4'hF, 4'h3, 3,           20,       0,           0,        3,                      1'b1, 3'b000, 3, 3, 0, 10, 3'b100);
    add(20,   0,       4'h6, 4'h0, 4'h0, 4'h3, 0,           22,       10,          3,        13,                     1'b1, 3'b000, 3, 13, 0, 10, 3'b000);
    add(22,   0,       4'h6, 4'h1, 4'h3, 4'h3, 0,           24,       13,          13,       0,                      1'b0, 3'b000, 3, 0, 0, 10, 3'b100);
    add(24,   0,       4'h7, 4'h4, 4'hF, 4'hF, 64'h1111,    33,       0,           0,        0,                      1'b0, 3'b000, 3, 0, 0, 10, 3'b100);
    add(33,   0,       4'h7, 4'h3, 4'hF, 4'hF, 64'h40,      42,       0,           0,        0,                      1'b1, 3'b000, 3, 0, 0, 10, 3'b100);
    add(42,   0,       4'h3, 4'h0, 4'hF, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 52, 0,     0,        64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 3'b000, 0, 64'h7FFF_FFFF_FFFF_FFFF, 3, 0, 3'b100);
    add(52,   0,       4'h3, 4'h0, 4'hF, 4'h3, 1,           62,       0,           0,        1,                      1'b1, 3'b000, 3, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 3'b100);
    add(62,   0,       4'h6, 4'h0, 4'h0, 4'h3, 0,           64,       64'h7FFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000, 1'b1, 3'b000, 3, 64'h8000_0000_0000_0000, 0, 64'h7FFF_FFFF_FFFF_FFFF, 3'b011);
    add(64,   0,       4'h3, 4'h0, 4'hF, 4'h4, 64'h100,     74,       0,           0,        64'h100,                1'b1, 3'b000, 4, 64'h100, 3, 64'h8000_0000_0000_0000, 3'b011);
    add(74,   0,       4'h3, 4'h0, 4'hF, 4'h0, 5,           84,       0,           0,        5,                      1'b1, 3'b000, 0, 5, 4, 64'h100, 3'b011);
    add(84,   0,       4'hA, 4'h0, 4'h0, 4'hF, 0,           86,       5,           64'h100,  64'hF8,                 1'b1, 3'b000, 4, 64'hF8, 0, 5, 3'b011);
    add(86,   64'h55,  4'hB, 4'h0, 4'h1, 4'hF, 0,           88,       64'hF8,      64'hF8,   64'h100,                1'b1, 3'b000, 1, 64'h55, 4, 64'h100, 3'b011);
    add(88,   0,       4'hC, 4'h0, 4'hF, 4'hF, 0,           89,       0,           0,        0,                      1'b1, 3'b100, 0, 5, 4, 64'h100, 3'b011);
    add(89,   0,       4'h0, 4'h0, 4'hF, 4'hF, 0,           90,       0,           0,        0,                      1'b1, 3'b001, 0, 5, 1, 64'h55, 3'b011);
    add(90,   64'h1234, 4'hB, 4'h0, 4'h4, 4'hF, 0,          92,       64'h100,     64'h100,  64'h108,                1'b1, 3'b000, 4, 64'h1234, 1, 64'h55, 3'b011);
    add(92,   0,       4'h2, 4'h0, 4'h0, 4'h1, 0,           94,       5,           0,        5,                      1'b1, 3'b000, 1, 5, 0, 5, 3'b011);
    add(94,   0,       4'h2, 4'h2, 4'h0, 4'h3, 0,           96,       5,           0,        5,                      1'b0, 3'b000, 3, 64'h8000_0000_0000_0000, 1, 5, 3'b011);
    add(96,   64'h77,  4'h5, 4'h0, 4'h2, 4'h4, 8,           106,      0,           64'h1234, 64'h123C,               1'b1, 3'b000, 2, 64'h77, 4, 64'h1234, 3'b011);
    add(106,  0,       4'h3, 4'h1, 4'hF, 4'h0, 64'h99,      116,      0,           0,        64'h99,                 1'b0, 3'b100, 0, 5, 2, 64'h77, 3'b011);
    add(1020, 0,       4'h3, 4'h0, 4'hF, 4'h0, 64'hAB,      1030,     0,           0,        64'hAB,                 1'b1, 3'b010, 0, 5, 4, 64'h1234, 3'b011);

    // Load instruction memory while reset is held.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      imem_we = 1'b1; imem_waddr = 10'(i); imem_wdata = prog[i];
    end
    @(negedge clk);
    imem_we = 1'b0;

    #1;
    for (int i = 0; i < 15; i++) chk($sformatf("reset_r%0d", i), rb[i], 64'd0);
    chk("reset_cc", {ZF, SF, OF}, 3'b100);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      @(negedge clk);
      pc = vecs[n].pc; valM = vecs[n].valm;
      #1;
      chk($sformatf("v%0d_fields", n), {icode, ifun, rA, rB},
          {vecs[n].icode, vecs[n].ifun, vecs[n].ra, vecs[n].rb});
      chk($sformatf("v%0d_valC", n), valC, vecs[n].valc);
      chk($sformatf("v%0d_valP", n), valP, vecs[n].valp);
      chk($sformatf("v%0d_valA", n), valA, vecs[n].vala);
      chk($sformatf("v%0d_valB", n), valB, vecs[n].valb);
      chk($sformatf("v%0d_valE", n), valE, vecs[n].vale);
      chk($sformatf("v%0d_cnd", n), cnd, vecs[n].cnd);
      chk($sformatf("v%0d_status", n), {invalid_inst, imem_error, halt}, vecs[n].st);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_r%0d", n, vecs[n].r1), rb[vecs[n].r1], vecs[n].v1);
      chk($sformatf("v%0d_r%0d", n, vecs[n].r2), rb[vecs[n].r2], vecs[n].v2);
      chk($sformatf("v%0d_cc", n), {ZF, SF, OF}, vecs[n].cc);
    end

    // Overwriting the byte under fetch is only visible after the edge.
    @(negedge clk);
    pc = 64'd200;
    imem_we = 1'b1; imem_waddr = 10'd200; imem_wdata = 8'h00;
    #1;
    chk("wr_fetch_before", icode, 4'h1);
    chk("wr_fetch_halt_before", halt, 1'b0);
    @(posedge clk);
    #1;
    imem_we = 1'b0;
    chk("wr_fetch_after", icode, 4'h0);
    chk("wr_fetch_halt_after", halt, 1'b1);

    // Asynchronous reset mid-run clears registers at once and blocks commit.
    @(negedge clk);
    pc = 64'd0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) chk($sformatf("midrst_r%0d", i), rb[i], 64'd0);
    chk("midrst_cc", {ZF, SF, OF}, 3'b100);
    @(posedge clk);
    #1;
    chk("rst_held_no_write", rb[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_imem_kept", rb[0], 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
